// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding decode; sequential fetches over imem req/ack, flushed on redirect.
// Latency: an entry acked at one falling edge is presented on inst_id right after it (no bypass).
// Backpressure: decode stall holds the head; new fetches issue only when a slot is guaranteed free.

module fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_vld,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Falling-edge storage so it lines up with the pipeline interstage registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CNT_W'(push_vld) - CNT_W'(pop_vld);
        end
    end

    always_ff @(negedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 3
) (
    input  logic             clk,
    input  logic             initPC,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [0:31]      imem_rdata,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             stall,
    output logic [0:31]      inst_id,
    output logic [31:0]      pc_id,
    output logic [31:0]      pcPlusFour_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] count
);
    localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [0:31] inst;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t            state, state_nx;
    logic [31:0]       fetch_pc;
    logic [31:0]       drop_addr;
    logic              pop_vld;
    logic              push_vld;
    logic [CNT_W-1:0]  occ_after_pop;
    logic              space_now;
    logic              space_after_push;
    entry_t            head;
    entry_t            push_dat;

    assign valid_id         = (count != '0);
    assign pop_vld          = valid_id && !stall && !redirect;
    assign push_vld         = imem_req && imem_ack && (state == FETCH) && !redirect;
    assign occ_after_pop    = count - CNT_W'(pop_vld);
    assign space_now        = occ_after_pop < CNT_W'(DEPTH);
    assign space_after_push = (occ_after_pop + CNT_W'(1)) < CNT_W'(DEPTH);
    assign push_dat         = '{pc: fetch_pc, inst: imem_rdata};

    fifo #(.W($bits(entry_t)), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk      (clk),
        .rst      (initPC),
        .flush    (redirect),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head),
        .count    (count)
    );

    assign inst_id       = valid_id ? head.inst : '0;
    assign pc_id         = valid_id ? head.pc : '0;
    assign pcPlusFour_id = pc_id + 32'd4;

    always_ff @(negedge clk or posedge initPC) begin
        if (initPC) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC & ALIGN;
            drop_addr <= '0;
        end else begin
            state <= state_nx;
            if (redirect)      fetch_pc <= redirect_pc & ALIGN;
            else if (push_vld) fetch_pc <= fetch_pc + 32'd4;
            // An abandoned request must keep presenting its original address until acked.
            if (state == FETCH && state_nx == DROP) drop_addr <= fetch_pc;
        end
    end

    always_comb begin
        state_nx  = state;
        imem_req  = (state != IDLE);
        imem_addr = (state == DROP) ? drop_addr : fetch_pc;
        case (state)
            IDLE: begin
                if (redirect || space_now) state_nx = FETCH;
            end
            FETCH: begin
                if (redirect)      state_nx = imem_ack ? FETCH : DROP;
                else if (imem_ack) state_nx = space_after_push ? FETCH : IDLE;
            end
            DROP: begin
                if (imem_ack) state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue directly upstream of the decode stage. It replaces the direct PC-to-instruction-memory path.
- Issues sequential fetches to instruction memory over a req/ack handshake and buffers up to DEPTH (pc, instruction) pairs.
- Presents the head entry to decode as inst_id / pcPlusFour_id.
- Honours decode stall, and flushes the queue on a branch/jump redirect from control.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- CNT_W, 3, width of count output; must hold DEPTH.

Ports:
- clk  input  1  system clock; all state updates on negedge clk, matching the pipeline interstage registers.
- initPC  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; held high until accepted.
- imem_addr  output  32  word-aligned fetch address; stable while imem_req is high.
- imem_ack  input  1  instruction memory response; a transaction completes at the edge where imem_req && imem_ack.
- imem_rdata  input  [0:31]  instruction word; valid when imem_ack.
- redirect  input  1  taken branch/jump from decode control (should_branch_id).
- redirect_pc  input  32  target (new_pc_if_jump_id); bits [1:0] ignored and forced to 0.
- stall  input  1  decode stall; head is not consumed.
- inst_id  output  [0:31]  head instruction; 32'h0000_0000 (NOP) when not valid.
- pc_id  output  32  PC of head instruction.
- pcPlusFour_id  output  32  pc_id + 4, modulo 2^32.
- valid_id  output  1  head entry valid.
- count  output  CNT_W  occupied entries.

Behaviour:
- Reset (async, initPC=1), applied immediately:
  - fetch_pc=RESET_PC, queue empty, count=0, valid_id=0, inst_id=0, pc_id=0, pcPlusFour_id=4, imem_req=0, state=IDLE.
  - Reset mid-transaction abandons it; an ack arriving while initPC is high is ignored.
- Pop: occurs at an edge where valid_id && !stall && !redirect. Head outputs are combinational from the head entry, so zero extra latency beyond storage.
- Push: occurs at an edge where imem_req && imem_ack && state==FETCH && !redirect. Writes {fetch_pc, imem_rdata} at the tail and sets fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 0.
- Simultaneous push and pop keeps count unchanged.
- Issue gating: a new request is started only when (count - pop_this_edge) < DEPTH, so the queue can never overflow. Push never coincides with a full queue without a pop.
- Bypass: none. An instruction acked at edge N appears on inst_id after edge N, so the minimum fetch-to-decode latency is 1 cycle.
- At most one outstanding request.
- FSM:
  - IDLE: imem_req=0.
    - Go to FETCH when there is space; imem_addr=fetch_pc.
  - FETCH: imem_req=1.
    - On ack: push. Stay in FETCH if space remains after the push, else go to IDLE.
    - On redirect without ack: go to DROP.
    - On redirect with ack: discard the data, go to FETCH or IDLE at redirect_pc.
  - DROP: imem_req=1 with the stale address until ack, because the request cannot be withdrawn.
    - On ack: discard the data, go to FETCH at the new fetch_pc.
    - A further redirect in DROP only updates fetch_pc.
- Redirect (highest priority, applied at the edge where redirect=1):
  - Queue flushed: count=0, valid_id=0 after the edge.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - Any pop or push on that edge is suppressed.
- Redirect while stall=1 still flushes.
- imem_addr is always {x[31:2],2'b00}. The queue never reorders entries.
- Head/tail pointers are log2(DEPTH) bits, wrap naturally. count is updated as +push-pop.

Test Plan:
- Reset then 1-cycle-latency memory, stall=0 → imem_addr 0,4,8,C; decode sees pc_id 0,4,8 in order; pcPlusFour_id = pc_id+4; count stays ≤1.
- stall=1 held for 10 cycles, ack every cycle → count reaches 4 and stays there; imem_req drops to 0; release stall → four entries drain in order PC 0,4,8,C, then fetch resumes at 0x10.
- Full queue, then redirect=1 with redirect_pc=0x0000_0103 → next edge count=0, valid_id=0; next request address 0x100; first delivered pc_id=0x100.
- Redirect to 0x200 while a request to 0x14 is outstanding, ack delayed 3 cycles → state DROP; returning 0x14 data is never seen on inst_id; next imem_addr=0x200.
- Redirect coinciding with ack and a pop on the same edge → ack data discarded, no pop counted, count=0, next fetch at redirect target.
- Assert initPC for half a cycle mid-FETCH with the queue holding 2 entries → outputs immediately return to reset values; after release first imem_addr=RESET_PC; fetch_pc wrap test from 0xFFFF_FFFC → next fetch 0x0000_0000.
